seq_divider: RTL and testbench
==============================

# seq_divider

Iterative unsigned restoring divider that undoes the work of the pipelined multiplier: it takes a 2*WIDTH-bit dividend (a product-width value) and a WIDTH-bit divisor and returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder. It retires one quotient bit per enabled cycle under a start/busy/done handshake. It sits next to the multiplier in the arithmetic datapath for normalisation and scaling steps, where area matters more than throughput.

## Interface
- WIDTH, 8, divisor and remainder width; dividend and quotient are 2*WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  iteration enable; low in RUN freezes all state (stall).
- start  in  1  request; sampled only in IDLE.
- dataa  in  2*WIDTH  dividend, unsigned; captured on an accepted start.
- datab  in  WIDTH  divisor, unsigned; captured on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when quot/rem/dbz are updated.
- quot  out  2*WIDTH  quotient, registered.
- rem  out  WIDTH  remainder, registered.
- dbz  out  1  divide-by-zero flag for the most recent result.

## Operation
- State machine: IDLE and RUN.
  - Counter cnt is ceil(log2(2*WIDTH)) bits.
  - Partial remainder R is WIDTH+1 bits.
  - Working quotient/shift register Q is 2*WIDTH bits.
  - Captured divisor D is WIDTH bits.
- Start is accepted when start=1 in IDLE; enable is ignored in IDLE.
- On an accepted start with datab != 0:
  - Q <= dataa, R <= 0, D <= datab, cnt <= 0.
  - Move to RUN.
- On an accepted start with datab == 0:
  - Stay in IDLE.
  - Next edge result: quot <= all ones, rem <= dataa[WIDTH-1:0], dbz <= 1, done <= 1.
- RUN iteration, on each edge with enable=1:
  - Form T = {R[WIDTH-1:0], Q[2W-1]}.
  - If T >= D: R <= T - D and Q <= {Q[2W-2:0], 1}.
  - Otherwise: R <= T and Q <= {Q[2W-2:0], 0}.
  - cnt <= cnt + 1.
- At the iteration with cnt == 2*WIDTH-1:
  - Write quot and rem from the post-iteration values of Q and R[WIDTH-1:0].
  - dbz <= 0, done <= 1.
  - Return to IDLE.
- RUN with enable=0: Q, R, cnt and state hold; done stays 0.
- done is high for exactly one cycle per result and is 0 at all other times.
- quot, rem and dbz hold their values until the next result is written.
- start while busy=1 is ignored; the operands in flight are not disturbed.
- Arithmetic: R never exceeds D-1 after an iteration, so rem fits in WIDTH bits. The compare uses WIDTH+1 bits and there is no overflow.
- Results satisfy dataa == quot*datab + rem and rem < datab for all datab != 0.

## Timing
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, dbz=0, quot=0, rem=0; cnt, Q, R and D are cleared.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced for the aborted operation.
- Reset has priority over start and enable.
- Latency:
  - Start is accepted at edge N.
  - busy=1 from edge N through edge N+2*WIDTH+S, where S is the number of enable=0 cycles during RUN.
  - done=1 and the new outputs are visible in the cycle after edge N+2*WIDTH+S.
  - With WIDTH=8 and no stalls, done appears 16 cycles after the start edge.
- Divide by zero: done=1 in the cycle after edge N, a latency of 1; busy never asserts.
- Back-to-back: the done cycle is an IDLE cycle, so start can be accepted at the edge ending the done cycle. Sustained throughput is one result per 2*WIDTH+1 cycles.
- busy falls on the same edge on which done rises.

## Test plan
- WIDTH=8, start with dataa=1000, datab=7 -> 16 cycles later done=1, quot=142, rem=6, dbz=0; busy high for exactly 16 cycles.
- Corner operands, checked one at a time:
  - dataa=65535, datab=1 -> quot=65535, rem=0.
  - dataa=65535, datab=255 -> quot=257, rem=0.
  - dataa=100, datab=200 -> quot=0, rem=100.
- dataa=1234, datab=0 -> done on the next cycle, dbz=1, quot=16'hFFFF, rem=8'hD2, busy stays 0.
- Start 1000/7, hold enable=0 for 5 cycles mid-RUN, and pulse start during busy with 5/5 -> done at 21 cycles with quot=142, rem=6; the 5/5 request is ignored.
- Back-to-back: assert start in the done cycle with 300/17 -> second done 17 cycles after the first, with quot=17, rem=11.
- Reset on cycle 8 of a 1000/7 operation -> busy=0, quot=0, rem=0 on the next cycle, no done pulse; a following 50/3 gives quot=16, rem=2.

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/result bundle for the iterative restoring divider.
// The requester side is master and the divider side is slave.
interface seq_divider_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 enable;
   logic [2*WIDTH-1:0]   dataa;
   logic [WIDTH-1:0]     datab;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   quot;
   logic [WIDTH-1:0]     rem;
   logic                 dbz;

   modport master (
      output start, enable, dataa, datab,
      input  busy, done, quot, rem, dbz
   );

   modport slave (
      input  start, enable, dataa, datab,
      output busy, done, quot, rem, dbz
   );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per enabled cycle, start/busy/done handshake.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   seq_divider_if.slave bus
);
   localparam int QW = 2 * WIDTH;
   localparam int CW = $clog2(QW);
   localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH:0]    r_q, r_d;
   logic [QW-1:0]     q_q, q_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic [QW-1:0]     quot_q, quot_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic              dbz_q, dbz_d;
   logic              done_q, done_d;

   logic [WIDTH:0]    t;
   logic              ge;
   logic [WIDTH:0]    r_nxt;
   logic [QW-1:0]     q_nxt;

   // One restoring step; R < D holds, so T fits in WIDTH+1 bits.
   always_comb begin
      t     = {r_q[WIDTH-1:0], q_q[QW-1]};
      ge    = (t >= {1'b0, d_q});
      r_nxt = ge ? (t - {1'b0, d_q}) : t;
      q_nxt = {q_q[QW-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.datab == '0) begin
                  quot_d = '1;
                  rem_d  = bus.dataa[WIDTH-1:0];
                  dbz_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  q_d     = bus.dataa;
                  r_d     = '0;
                  d_d     = bus.datab;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (bus.enable) begin
               q_d   = q_nxt;
               r_d   = r_nxt;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  quot_d  = q_nxt;
                  rem_d   = r_nxt[WIDTH-1:0];
                  dbz_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = done_q;
   assign bus.quot = quot_q;
   assign bus.rem  = rem_q;
   assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with hand-computed quotients,
// checked by immediate assertions after each clock edge.
module tb_seq_divider;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   lat;
   int   bcnt;
   int   tot;
   logic seen;

   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(8)) bus ();

   seq_divider #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] a,
                           input logic [7:0] b);
      bus.dataa = a;
      bus.datab = b;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // Counts post-edge samples until done, and busy samples seen.
   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = 0;
      while (!bus.done && l < 60) begin
         if (bus.busy) bc++;
         step();
         l++;
      end
      if (!bus.done) chk("timeout", 32'(bus.done), 32'd1);
   endtask

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.enable = 1'b1;
      bus.dataa  = '0;
      bus.datab  = '0;
      step();
      step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dbz",  32'(bus.dbz),  32'd0);
      chk("rst_quot", 32'(bus.quot), 32'd0);
      chk("rst_rem",  32'(bus.rem),  32'd0);
      reset = 1'b0;
      step();

      // 1000 / 7
      start_op(16'd1000, 8'd7);
      chk("b1_busy0", 32'(bus.busy), 32'd1);
      wait_done(lat, bcnt);
      chk("b1_lat",  32'(lat),      32'd16);
      chk("b1_bcnt", 32'(bcnt),     32'd16);
      chk("b1_busy", 32'(bus.busy), 32'd0);
      chk("b1_quot", 32'(bus.quot), 32'd142);
      chk("b1_rem",  32'(bus.rem),  32'd6);
      chk("b1_dbz",  32'(bus.dbz),  32'd0);
      step();
      chk("b1_pulse", 32'(bus.done), 32'd0);
      chk("b1_hold",  32'(bus.quot), 32'd142);

      // corner operands
      start_op(16'd65535, 8'd1);
      wait_done(lat, bcnt);
      chk("c1_quot", 32'(bus.quot), 32'd65535);
      chk("c1_rem",  32'(bus.rem),  32'd0);
      step();
      start_op(16'd65535, 8'd255);
      wait_done(lat, bcnt);
      chk("c2_quot", 32'(bus.quot), 32'd257);
      chk("c2_rem",  32'(bus.rem),  32'd0);
      step();
      start_op(16'd100, 8'd200);
      wait_done(lat, bcnt);
      chk("c3_quot", 32'(bus.quot), 32'd0);
      chk("c3_rem",  32'(bus.rem),  32'd100);
      step();

      // divide by zero
      start_op(16'd1234, 8'd0);
      chk("z_done", 32'(bus.done), 32'd1);
      chk("z_busy", 32'(bus.busy), 32'd0);
      chk("z_dbz",  32'(bus.dbz),  32'd1);
      chk("z_quot", 32'(bus.quot), 32'hFFFF);
      chk("z_rem",  32'(bus.rem),  32'hD2);
      step();
      chk("z_pulse", 32'(bus.done), 32'd0);
      chk("z_busy2", 32'(bus.busy), 32'd0);
      chk("z_hold",  32'(bus.dbz),  32'd1);

      // stall 5 cycles, plus a start during busy that must be ignored
      start_op(16'd1000, 8'd7);
      step();
      step();
      step();
      bus.enable = 1'b0;
      bus.start  = 1'b1;
      bus.dataa  = 16'd5;
      bus.datab  = 8'd5;
      for (int i = 0; i < 5; i++) step();
      chk("s_busy", 32'(bus.busy), 32'd1);
      bus.enable = 1'b1;
      bus.start  = 1'b0;
      wait_done(lat, bcnt);
      tot = 8 + lat;
      chk("s_lat",  32'(tot),       32'd21);
      chk("s_quot", 32'(bus.quot), 32'd142);
      chk("s_rem",  32'(bus.rem),  32'd6);
      chk("s_dbz",  32'(bus.dbz),  32'd0);

      // back-to-back: start in the done cycle
      start_op(16'd300, 8'd17);
      chk("bb_busy", 32'(bus.busy), 32'd1);
      wait_done(lat, bcnt);
      tot = 1 + lat;
      chk("bb_gap",  32'(tot),      32'd17);
      chk("bb_quot", 32'(bus.quot), 32'd17);
      chk("bb_rem",  32'(bus.rem),  32'd11);
      step();

      // reset mid-run aborts without a done pulse
      start_op(16'd1000, 8'd7);
      for (int i = 0; i < 7; i++) step();
      reset = 1'b1;
      step();
      chk("r_busy", 32'(bus.busy), 32'd0);
      chk("r_quot", 32'(bus.quot), 32'd0);
      chk("r_rem",  32'(bus.rem),  32'd0);
      chk("r_done", 32'(bus.done), 32'd0);
      reset = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.done) seen = 1'b1;
      end
      chk("r_nodone", 32'(seen), 32'd0);
      start_op(16'd50, 8'd3);
      wait_done(lat, bcnt);
      chk("r2_lat",  32'(lat),      32'd16);
      chk("r2_quot", 32'(bus.quot), 32'd16);
      chk("r2_rem",  32'(bus.rem),  32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
